// File: rtl/nlc_frame_assembler.sv
// Double-buffered frame assembler feeding the 16-channel NLC core: collects
// channel-ordered ADC samples into one bank while the other bank is held for the core.
module nlc_frame_assembler #(
    parameter int NCH  = 16,
    parameter int W    = 21,
    parameter int ERRW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        s_chan,
    input  logic [W-1:0]      s_data,
    output logic [NCH*W-1:0]  x_adc_o,
    output logic              srdyi_o,
    input  logic              nlc_srdyo_i,
    output logic              busy_o,
    output logic              seq_err_o,
    output logic [ERRW-1:0]   err_cnt_o
);

    localparam logic [3:0]      LAST_CH = 4'(NCH - 1);
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    logic [W-1:0]    bank_q [2][NCH];
    logic            wr_bank_q;
    logic            wr_bank_d;
    logic            rd_bank_q;
    logic [3:0]      wr_cnt_q;
    logic [3:0]      wr_cnt_d;
    logic [1:0]      full_q;
    logic [1:0]      full_d;
    state_e          state_q;
    logic            srdyi_q;
    logic            busy_q;
    logic            seq_err_q;
    logic            seq_err_d;
    logic [ERRW-1:0] err_cnt_q;
    logic [ERRW-1:0] err_cnt_d;

    logic            accept_s;
    logic            in_order_s;
    logic            store_s;
    logic [3:0]      store_idx_s;
    logic            frame_done_s;
    logic            release_s;

    assign s_ready   = ~full_q[wr_bank_q];
    assign srdyi_o   = srdyi_q;
    assign busy_o    = busy_q;
    assign seq_err_o = seq_err_q;
    assign err_cnt_o = err_cnt_q;

    // Write-side decode: ordering check, store target, frame completion and error bookkeeping
    always_comb begin
        accept_s     = s_valid && ~full_q[wr_bank_q];
        in_order_s   = (s_chan == wr_cnt_q);
        store_s      = 1'b0;
        store_idx_s  = wr_cnt_q;
        frame_done_s = 1'b0;
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        seq_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        if (accept_s) begin
            if (in_order_s) begin
                store_s = 1'b1;
                if (wr_cnt_q == LAST_CH) begin
                    frame_done_s = 1'b1;
                    wr_cnt_d     = 4'd0;
                    wr_bank_d    = ~wr_bank_q;
                end else begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                end
            end else begin
                seq_err_d = 1'b1;
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                // A channel-0 sample out of order restarts the frame rather than being lost
                if (s_chan == 4'd0) begin
                    store_s     = 1'b1;
                    store_idx_s = 4'd0;
                    wr_cnt_d    = 4'd1;
                end else begin
                    wr_cnt_d = 4'd0;
                end
            end
        end else begin
            store_s = 1'b0;
        end
    end

    // Full-flag next state: release of the read bank and completion of the write bank can coincide
    always_comb begin
        release_s = (state_q == ST_WAIT) && nlc_srdyo_i;
        full_d    = full_q;
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d[rd_bank_q] = full_q[rd_bank_q];
        end
        if (frame_done_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d[wr_bank_q] = full_d[wr_bank_q];
        end
    end

    // Presented frame is a straight mux of the read bank; a full bank is never written
    always_comb begin
        x_adc_o = {(NCH*W){1'b0}};
        for (int c = 0; c < NCH; c++) begin
            x_adc_o[c*W +: W] = bank_q[rd_bank_q][c];
        end
    end

    // Sample storage for both banks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCH; c++) begin
                    bank_q[b][c] <= {W{1'b0}};
                end
            end
        end else if (store_s) begin
            bank_q[wr_bank_q][store_idx_s] <= s_data;
        end
    end

    // Write pointer, write bank and sequence-error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_q  <= 4'd0;
            wr_bank_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= {ERRW{1'b0}};
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Per-bank full flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // Issue FSM with registered srdyi/busy and the read-bank pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            srdyi_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q <= ST_ISSUE;
                        srdyi_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        srdyi_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    srdyi_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                ST_WAIT: begin
                    srdyi_q <= 1'b0;
                    if (nlc_srdyo_i) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        rd_bank_q <= ~rd_bank_q;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    srdyi_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nlc_frame_assembler.sv
// Directed bench for nlc_frame_assembler: frame issue timing, double buffering,
// sequence-error handling, counter saturation and asynchronous reset.
module tb_nlc_frame_assembler;

    localparam int NCH  = 16;
    localparam int W    = 21;
    localparam int ERRW = 8;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [3:0]        s_chan;
    logic [W-1:0]      s_data;
    logic [NCH*W-1:0]  x_adc_o;
    logic              srdyi_o;
    logic              nlc_srdyo_i;
    logic              busy_o;
    logic              seq_err_o;
    logic [ERRW-1:0]   err_cnt_o;

    int vectors;
    int miscompares;

    nlc_frame_assembler #(.NCH(NCH), .W(W), .ERRW(ERRW)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_chan      (s_chan),
        .s_data      (s_data),
        .x_adc_o     (x_adc_o),
        .srdyi_o     (srdyi_o),
        .nlc_srdyo_i (nlc_srdyo_i),
        .busy_o      (busy_o),
        .seq_err_o   (seq_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame 0 is c*0x1111; other frames are scrambled so banks are distinguishable
    function automatic logic [W-1:0] fdat(input int f, input int c);
        logic [31:0] v;
        v = (c * 32'h1111) ^ (f * 32'h0F0F3);
        return v[W-1:0];
    endfunction

    function automatic logic [NCH*W-1:0] frame_vec(input int f);
        logic [NCH*W-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*W +: W] = fdat(f, c);
        return v;
    endfunction

    task automatic send(input logic [3:0] ch, input logic [W-1:0] d);
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_srdyo();
        nlc_srdyo_i = 1'b1;
        @(posedge clk); #1;
        nlc_srdyo_i = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0; nlc_srdyo_i = 1'b0;
        #1 reset = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        vectors += 6;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL reset_srdyi: got %b expected 0", srdyi_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        if (seq_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_seq_err: got %b expected 0", seq_err_o); end
        if (err_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o); end
        if (x_adc_o !== '0) begin miscompares++; $display("FAIL reset_x_adc: got %0h expected 0", x_adc_o); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single_frame();
        for (int c = 0; c < NCH; c++) begin
            vectors++;
            if (s_ready !== 1'b1) begin miscompares++; $display("FAIL f1_s_ready ch%0d: got %b expected 1", c, s_ready); end
            send(4'(c), fdat(0, c));
            vectors++;
            if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL f1_early_srdyi ch%0d: got %b expected 0", c, srdyi_o); end
        end
        s_valid = 1'b0;
        step();
        vectors += 2;
        if (srdyi_o !== 1'b1) begin miscompares++; $display("FAIL f1_srdyi_pulse: got %b expected 1", srdyi_o); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL f1_busy_issue: got %b expected 1", busy_o); end
        step();
        vectors += 3;
        if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL f1_srdyi_width: got %b expected 0", srdyi_o); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL f1_busy_wait: got %b expected 1", busy_o); end
        if (x_adc_o !== frame_vec(0)) begin miscompares++; $display("FAIL f1_x_adc: got %0h expected %0h", x_adc_o, frame_vec(0)); end
    endtask

    task automatic test_double_buffer();
        for (int c = 0; c < NCH; c++) send(4'(c), fdat(1, c));
        vectors++;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL db_both_full_ready: got %b expected 0", s_ready); end
        s_valid = 1'b1; s_chan = 4'd0; s_data = fdat(2, 0);
        step(); step(); step();
        vectors += 4;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL db_stall_ready: got %b expected 0", s_ready); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL db_stall_busy: got %b expected 1", busy_o); end
        if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL db_stall_srdyi: got %b expected 0", srdyi_o); end
        if (x_adc_o !== frame_vec(0)) begin miscompares++; $display("FAIL db_hold_x_adc: got %0h expected %0h", x_adc_o, frame_vec(0)); end
        pulse_srdyo();
        vectors += 3;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL db_release_busy: got %b expected 0", busy_o); end
        if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL db_release_srdyi: got %b expected 0", srdyi_o); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL db_release_ready: got %b expected 1", s_ready); end
        step();
        vectors += 2;
        if (srdyi_o !== 1'b1) begin miscompares++; $display("FAIL db_f2_srdyi: got %b expected 1", srdyi_o); end
        if (x_adc_o !== frame_vec(1)) begin miscompares++; $display("FAIL db_f2_x_adc: got %0h expected %0h", x_adc_o, frame_vec(1)); end
        for (int c = 1; c < NCH; c++) send(4'(c), fdat(2, c));
        s_valid = 1'b0;
        vectors += 2;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL db_f3_full_ready: got %b expected 0", s_ready); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL db_f3_busy: got %b expected 1", busy_o); end
        pulse_srdyo();
        step();
        vectors += 2;
        if (srdyi_o !== 1'b1) begin miscompares++; $display("FAIL db_f3_srdyi: got %b expected 1", srdyi_o); end
        if (x_adc_o !== frame_vec(2)) begin miscompares++; $display("FAIL db_f3_x_adc: got %0h expected %0h", x_adc_o, frame_vec(2)); end
        step();
        pulse_srdyo();
        vectors += 2;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL db_f3_release_busy: got %b expected 0", busy_o); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL db_f3_release_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_seq_err_drop();
        do_reset();
        for (int c = 0; c < 3; c++) send(4'(c), fdat(3, c));
        send(4'd5, fdat(3, 5));
        s_valid = 1'b0;
        vectors += 2;
        if (seq_err_o !== 1'b1) begin miscompares++; $display("FAIL drop_seq_err: got %b expected 1", seq_err_o); end
        if (err_cnt_o !== 8'd1) begin miscompares++; $display("FAIL drop_err_cnt: got %0d expected 1", err_cnt_o); end
        step();
        vectors++;
        if (seq_err_o !== 1'b0) begin miscompares++; $display("FAIL drop_seq_err_width: got %b expected 0", seq_err_o); end
        for (int c = 0; c < NCH; c++) begin
            send(4'(c), fdat(4, c));
            vectors++;
            if (seq_err_o !== 1'b0) begin miscompares++; $display("FAIL drop_clean_seq_err ch%0d: got %b expected 0", c, seq_err_o); end
        end
        s_valid = 1'b0;
        step();
        vectors++;
        if (srdyi_o !== 1'b1) begin miscompares++; $display("FAIL drop_clean_srdyi: got %b expected 1", srdyi_o); end
        step();
        vectors += 2;
        if (x_adc_o !== frame_vec(4)) begin miscompares++; $display("FAIL drop_clean_x_adc: got %0h expected %0h", x_adc_o, frame_vec(4)); end
        if (err_cnt_o !== 8'd1) begin miscompares++; $display("FAIL drop_clean_err_cnt: got %0d expected 1", err_cnt_o); end
        pulse_srdyo();
    endtask

    task automatic test_resync();
        logic [NCH*W-1:0] exp_v;
        do_reset();
        for (int c = 0; c < 7; c++) send(4'(c), fdat(5, c));
        send(4'd0, 21'h1ABCD);
        vectors += 2;
        if (seq_err_o !== 1'b1) begin miscompares++; $display("FAIL resync_seq_err: got %b expected 1", seq_err_o); end
        if (err_cnt_o !== 8'd1) begin miscompares++; $display("FAIL resync_err_cnt: got %0d expected 1", err_cnt_o); end
        for (int c = 1; c < NCH; c++) begin
            send(4'(c), fdat(6, c));
            vectors++;
            if (seq_err_o !== 1'b0) begin miscompares++; $display("FAIL resync_tail_seq_err ch%0d: got %b expected 0", c, seq_err_o); end
        end
        s_valid = 1'b0;
        step();
        vectors++;
        if (srdyi_o !== 1'b1) begin miscompares++; $display("FAIL resync_srdyi: got %b expected 1", srdyi_o); end
        step();
        exp_v = frame_vec(6);
        exp_v[0 +: W] = 21'h1ABCD;
        vectors++;
        if (x_adc_o !== exp_v) begin miscompares++; $display("FAIL resync_x_adc: got %0h expected %0h", x_adc_o, exp_v); end
        pulse_srdyo();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(4'd1, 21'h00000);
            if (i == 253) begin
                vectors++;
                if (err_cnt_o !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d expected 254", err_cnt_o); end
            end
            if (i == 254) begin
                vectors++;
                if (err_cnt_o !== 8'd255) begin miscompares++; $display("FAIL sat_255: got %0d expected 255", err_cnt_o); end
            end
        end
        s_valid = 1'b0;
        vectors += 3;
        if (err_cnt_o !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d expected 255", err_cnt_o); end
        if (seq_err_o !== 1'b1) begin miscompares++; $display("FAIL sat_seq_err: got %b expected 1", seq_err_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL sat_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        send(4'd3, 21'h00033);
        for (int c = 0; c < NCH; c++) send(4'(c), fdat(7, c));
        s_valid = 1'b0;
        step(); step();
        for (int c = 0; c < NCH; c++) send(4'(c), fdat(8, c));
        s_valid = 1'b0;
        vectors += 3;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rmw_pre_ready: got %b expected 0", s_ready); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rmw_pre_busy: got %b expected 1", busy_o); end
        if (err_cnt_o !== 8'd1) begin miscompares++; $display("FAIL rmw_pre_err_cnt: got %0d expected 1", err_cnt_o); end
        #2 reset = 1'b0;
        #1;
        vectors += 6;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rmw_s_ready: got %b expected 1", s_ready); end
        if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL rmw_srdyi: got %b expected 0", srdyi_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmw_busy: got %b expected 0", busy_o); end
        if (seq_err_o !== 1'b0) begin miscompares++; $display("FAIL rmw_seq_err: got %b expected 0", seq_err_o); end
        if (err_cnt_o !== 8'd0) begin miscompares++; $display("FAIL rmw_err_cnt: got %0d expected 0", err_cnt_o); end
        if (x_adc_o !== '0) begin miscompares++; $display("FAIL rmw_x_adc: got %0h expected 0", x_adc_o); end
        step();
        reset = 1'b1;
        pulse_srdyo();
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (srdyi_o !== 1'b0) begin miscompares++; $display("FAIL rmw_stray_srdyi cyc%0d: got %b expected 0", i, srdyi_o); end
            if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmw_stray_busy cyc%0d: got %b expected 0", i, busy_o); end
            step();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        s_valid = 1'b0;
        s_chan = 4'd0;
        s_data = '0;
        nlc_srdyo_i = 1'b0;
        test_reset();
        test_single_frame();
        test_double_buffer();
        test_seq_err_drop();
        test_resync();
        test_saturation();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
